// File: rtl/spi_rom_loader.sv
// spi_rom_loader
//
// SPI mode-0 slave that feeds the write port of the dual-port boot ROM.
// The host streams a command byte, a 24-bit big-endian address and then data
// bytes.  Each data byte whose address falls inside the ROM window produces
// a one-cycle write strobe.  The address auto-increments after every data
// byte, whether or not that byte was written.
//
// Optional build macro: SPI_ROM_LOADER_CHECKSUM_EN
//   Adds output checksum[7:0].  It holds the modulo-256 sum of every byte
//   written since the last accepted write command, and keeps that value
//   after the transfer ends.
//
// Ports
//   clk       in   system clock, at least 4x SCLK
//   resetn    in   asynchronous active-low reset
//   spi_csn   in   chip select, active low, asynchronous to clk
//   spi_sclk  in   SPI clock (mode 0), asynchronous to clk
//   spi_mosi  in   serial data, MSB first
//   we_b      out  ROM write strobe, one clk wide
//   addr_b    out  ROM write address
//   din_b     out  ROM write data
//   loading   out  high while a valid write transfer is open
//   checksum  out  sum of written bytes (SPI_ROM_LOADER_CHECKSUM_EN only)
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | chip select high, waiting for it to fall
// S_CMD    | receiving the command byte
// S_ADDR   | receiving the three address bytes, MSB first
// S_DATA   | receiving data bytes, writing the in-window ones
// S_IGNORE | command not recognised, discard bytes until csn rises

module spi_rom_loader #(
   parameter int          ADDRESS_WIDTH = 14,
   parameter int          DATA_WIDTH    = 8,   // only 8 is supported
   parameter logic [23:0] BASE_ADDR     = 24'h000000,
   parameter logic [7:0]  CMD_WRITE     = 8'h00
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     spi_csn,
   input  logic                     spi_sclk,
   input  logic                     spi_mosi,
   output logic                     we_b,
   output logic [ADDRESS_WIDTH-1:0] addr_b,
   output logic [DATA_WIDTH-1:0]    din_b,
   output logic                     loading
`ifdef SPI_ROM_LOADER_CHECKSUM_EN
   ,
   output logic [7:0]               checksum
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_IGNORE
   } state_t;

   localparam logic [24:0] WIN_SIZE = 25'(1) << ADDRESS_WIDTH;

   // synchronisers and edge detection
   logic [1:0] r_csn_sync;
   logic [1:0] r_sclk_sync;
   logic [1:0] r_mosi_sync;
   logic       r_csn_d;
   logic       r_sclk_d;
   logic       w_csn;
   logic       w_csn_fall;
   logic       w_csn_rise;
   logic       w_sclk_rise;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_csn_sync  <= 2'b11;
         r_sclk_sync <= 2'b00;
         r_mosi_sync <= 2'b00;
         r_csn_d     <= 1'b1;
         r_sclk_d    <= 1'b0;
      end else begin
         r_csn_sync  <= {r_csn_sync[0], spi_csn};
         r_sclk_sync <= {r_sclk_sync[0], spi_sclk};
         r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
         r_csn_d     <= r_csn_sync[1];
         r_sclk_d    <= r_sclk_sync[1];
      end
   end

   assign w_csn       = r_csn_sync[1];
   assign w_csn_fall  = ~w_csn & r_csn_d;
   assign w_csn_rise  = w_csn & ~r_csn_d;
   assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_d;

   // byte assembly; r_byte_done pulses the cycle after the 8th rising edge
   logic [7:0] r_shift;
   logic [2:0] r_bit_cnt;
   logic       r_byte_done;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_shift     <= 8'h00;
         r_bit_cnt   <= 3'd0;
         r_byte_done <= 1'b0;
      end else begin
         r_byte_done <= 1'b0;
         if (w_csn) begin
            r_bit_cnt <= 3'd0;
         end else if (w_sclk_rise) begin
            r_shift     <= {r_shift[6:0], r_mosi_sync[1]};
            r_bit_cnt   <= r_bit_cnt + 3'd1;
            r_byte_done <= (r_bit_cnt == 3'd7);
         end
      end
   end

   // transfer FSM
   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [23:0]              r_addr;
   logic [23:0]              w_addr_nxt;
   logic [1:0]               r_aidx;
   logic [1:0]               w_aidx_nxt;
   logic                     r_we;
   logic                     w_we_nxt;
   logic [ADDRESS_WIDTH-1:0] r_addr_b;
   logic [ADDRESS_WIDTH-1:0] w_addr_b_nxt;
   logic [DATA_WIDTH-1:0]    r_din;
   logic [DATA_WIDTH-1:0]    w_din_nxt;
   logic                     r_loading;
   logic                     w_loading_nxt;
   logic [23:0]              w_off;
   logic                     w_in_win;
`ifdef SPI_ROM_LOADER_CHECKSUM_EN
   logic [7:0]               r_csum;
   logic [7:0]               w_csum_nxt;
`endif

   // modular offset: a single compare covers both window bounds
   assign w_off    = r_addr - BASE_ADDR;
   assign w_in_win = ({1'b0, w_off} < WIN_SIZE);

   always_comb begin
      w_state_nxt   = r_state;
      w_addr_nxt    = r_addr;
      w_aidx_nxt    = r_aidx;
      w_we_nxt      = 1'b0;
      w_addr_b_nxt  = r_addr_b;
      w_din_nxt     = r_din;
      w_loading_nxt = r_loading;
`ifdef SPI_ROM_LOADER_CHECKSUM_EN
      w_csum_nxt    = r_csum;
`endif
      if (w_csn_rise) begin
         w_state_nxt   = S_IDLE;
         w_loading_nxt = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_csn_fall) w_state_nxt = S_CMD;
            end
            S_CMD: begin
               if (r_byte_done) begin
                  if (r_shift == CMD_WRITE) begin
                     w_state_nxt   = S_ADDR;
                     w_loading_nxt = 1'b1;
                     w_aidx_nxt    = 2'd0;
`ifdef SPI_ROM_LOADER_CHECKSUM_EN
                     w_csum_nxt    = 8'h00;
`endif
                  end else begin
                     w_state_nxt = S_IGNORE;
                  end
               end
            end
            S_ADDR: begin
               if (r_byte_done) begin
                  w_addr_nxt = {r_addr[15:0], r_shift};
                  w_aidx_nxt = r_aidx + 2'd1;
                  if (r_aidx == 2'd2) w_state_nxt = S_DATA;
               end
            end
            S_DATA: begin
               if (r_byte_done) begin
                  if (w_in_win) begin
                     w_we_nxt     = 1'b1;
                     w_din_nxt    = r_shift;
                     w_addr_b_nxt = w_off[ADDRESS_WIDTH-1:0];
`ifdef SPI_ROM_LOADER_CHECKSUM_EN
                     w_csum_nxt   = r_csum + r_shift;
`endif
                  end
                  w_addr_nxt = r_addr + 24'd1;
               end
            end
            S_IGNORE: begin
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_addr    <= 24'h000000;
         r_aidx    <= 2'd0;
         r_we      <= 1'b0;
         r_addr_b  <= '0;
         r_din     <= '0;
         r_loading <= 1'b0;
`ifdef SPI_ROM_LOADER_CHECKSUM_EN
         r_csum    <= 8'h00;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_addr    <= w_addr_nxt;
         r_aidx    <= w_aidx_nxt;
         r_we      <= w_we_nxt;
         r_addr_b  <= w_addr_b_nxt;
         r_din     <= w_din_nxt;
         r_loading <= w_loading_nxt;
`ifdef SPI_ROM_LOADER_CHECKSUM_EN
         r_csum    <= w_csum_nxt;
`endif
      end
   end

   assign we_b    = r_we;
   assign addr_b  = r_addr_b;
   assign din_b   = r_din;
   assign loading = r_loading;
`ifdef SPI_ROM_LOADER_CHECKSUM_EN
   assign checksum = r_csum;
`endif

endmodule

// File: tb/tb_spi_rom_loader.sv
// Testbench for spi_rom_loader.  Two instances share one SPI bus: u_dut0 maps
// ROM location 0 to SPI address 0, u_dut1 maps it to SPI address 0x004000.
// A reference model pushes the expected writes into per-instance queues as
// each data byte's 8th SCLK edge is driven; monitors pop and compare them.

module tb_spi_rom_loader;

   localparam int          AW    = 14;
   localparam logic [23:0] BASE0 = 24'h000000;
   localparam logic [23:0] BASE1 = 24'h004000;

   logic          clk      = 1'b0;
   logic          resetn   = 1'b0;
   logic          spi_csn  = 1'b1;
   logic          spi_sclk = 1'b0;
   logic          spi_mosi = 1'b0;
   logic          we0, we1, ld0, ld1;
   logic [AW-1:0] a0, a1;
   logic [7:0]    d0, d1;
`ifdef SPI_ROM_LOADER_CHECKSUM_EN
   logic [7:0]    cs0, cs1;
`endif

   spi_rom_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(8), .BASE_ADDR(BASE0), .CMD_WRITE(8'h00)) u_dut0 (
      .clk(clk), .resetn(resetn), .spi_csn(spi_csn), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
      .we_b(we0), .addr_b(a0), .din_b(d0), .loading(ld0)
`ifdef SPI_ROM_LOADER_CHECKSUM_EN
      , .checksum(cs0)
`endif
   );

   spi_rom_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(8), .BASE_ADDR(BASE1), .CMD_WRITE(8'h00)) u_dut1 (
      .clk(clk), .resetn(resetn), .spi_csn(spi_csn), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
      .we_b(we1), .addr_b(a1), .din_b(d1), .loading(ld1)
`ifdef SPI_ROM_LOADER_CHECKSUM_EN
      , .checksum(cs1)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    data;
      int            cyc;
   } wr_t;

   wr_t q0[$];
   wr_t q1[$];
   wr_t e0, e1;
   int  checks = 0;
   int  errors = 0;
   int  wcnt0  = 0;
   int  wcnt1  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // expected write: 4 clk after the 8th SCLK rising edge at the pins
   task automatic model_push(input logic [23:0] a, input logic [7:0] b);
      logic [23:0] off0;
      logic [23:0] off1;
      wr_t         w;
      off0 = a - BASE0;
      off1 = a - BASE1;
      w.data = b;
      w.cyc  = cyc + 4;
      if (off0 < 24'h004000) begin
         w.addr = off0[AW-1:0];
         q0.push_back(w);
      end
      if (off1 < 24'h004000) begin
         w.addr = off1[AW-1:0];
         q1.push_back(w);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (we0 === 1'b1) begin
         wcnt0++;
         if (q0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr0_unexpected actual addr=%0h data=%0h required none", a0, d0);
         end else begin
            e0 = q0.pop_front();
            chk("wr0_addr", 32'(a0), 32'(e0.addr));
            chk("wr0_data", 32'(d0), 32'(e0.data));
            chk("wr0_latency_cyc", cyc, e0.cyc);
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (we1 === 1'b1) begin
         wcnt1++;
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr1_unexpected actual addr=%0h data=%0h required none", a1, d1);
         end else begin
            e1 = q1.pop_front();
            chk("wr1_addr", 32'(a1), 32'(e1.addr));
            chk("wr1_data", 32'(d1), 32'(e1.data));
            chk("wr1_latency_cyc", cyc, e1.cyc);
         end
      end
   end

   // SCLK period is 8 clk; all pin changes happen on the clk falling edge
   task automatic send_byte(input logic [7:0] b, input int nbits, input logic [23:0] a, input bit is_data);
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = b[7-i];
         repeat (4) @(negedge clk);
         spi_sclk = 1'b1;
         if (is_data && i == 7) model_push(a, b);
         repeat (4) @(negedge clk);
         spi_sclk = 1'b0;
      end
   endtask

   task automatic xfer(input logic [7:0] cmd, input logic [23:0] addr, input int n,
                       input logic [31:0] data, input bit ld_chk, input logic exp_ld, input int gap);
      @(negedge clk);
      spi_csn = 1'b0;
      repeat (4) @(negedge clk);
      send_byte(cmd, 8, 24'h0, 1'b0);
      for (int k = 0; k < 3; k++) send_byte(addr[23-8*k -: 8], 8, 24'h0, 1'b0);
      for (int i = 0; i < n; i++) send_byte(data[31-8*i -: 8], 8, addr + 24'(i), cmd == 8'h00);
      repeat (6) @(negedge clk);
      if (ld_chk) begin
         chk("loading_open_dut0", 32'(ld0), 32'(exp_ld));
         chk("loading_open_dut1", 32'(ld1), 32'(exp_ld));
      end
      spi_csn = 1'b1;
      if (ld_chk) begin
         repeat (3) @(posedge clk);
         #1;
         chk("loading_closed_dut0", 32'(ld0), 32'd0);
      end
      repeat (gap) @(negedge clk);
   endtask

   typedef struct {
      logic [7:0]  cmd;
      logic [23:0] addr;
      int          n;
      logic [31:0] data;
      int          w0;
      int          w1;
      logic        ld;
   } vec_t;

   vec_t tbl[6];
   int   b0, b1, bad;

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{8'h00, 24'h000010, 2, 32'hAA55_0000, 2, 0, 1'b1};
      tbl[1] = '{8'h00, 24'h003FFF, 3, 32'h1122_3300, 1, 2, 1'b1};
      tbl[2] = '{8'h5A, 24'h000000, 1, 32'hC300_0000, 0, 0, 1'b0};
      tbl[3] = '{8'h00, 24'h007FFE, 4, 32'h0102_0304, 0, 2, 1'b1};
      tbl[4] = '{8'h00, 24'hFFFFFE, 4, 32'hDEAD_BEEF, 2, 0, 1'b1};
      tbl[5] = '{8'h00, 24'h004002, 2, 32'h9A7E_0000, 0, 2, 1'b1};

      // SPI traffic while reset is held
      bad = 0;
      fork
         begin
            @(negedge clk);
            spi_csn = 1'b0;
            send_byte(8'h00, 8, 24'h0, 1'b0);
            send_byte(8'h00, 8, 24'h0, 1'b0);
            send_byte(8'h10, 8, 24'h0, 1'b0);
            send_byte(8'hAA, 8, 24'h0, 1'b0);
            spi_csn = 1'b1;
         end
         begin
            repeat (250) begin
               @(posedge clk);
               #1;
               if (we0 !== 1'b0 || ld0 !== 1'b0 || a0 !== '0 || d0 !== 8'h00 ||
                   we1 !== 1'b0 || ld1 !== 1'b0 || a1 !== '0 || d1 !== 8'h00) bad++;
            end
         end
      join
      chk("reset_hold_bad_cycles", bad, 0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_reset_we_b", 32'(we0), 32'd0);
      chk("post_reset_loading", 32'(ld0), 32'd0);
      chk("post_reset_addr_b", 32'(a0), 32'd0);
      chk("post_reset_din_b", 32'(d0), 32'd0);

      for (int i = 0; i < 6; i++) begin
         b0 = wcnt0;
         b1 = wcnt1;
         xfer(tbl[i].cmd, tbl[i].addr, tbl[i].n, tbl[i].data, 1'b1, tbl[i].ld, 8);
         chk($sformatf("vec%0d_writes_dut0", i), wcnt0 - b0, tbl[i].w0);
         chk($sformatf("vec%0d_writes_dut1", i), wcnt1 - b1, tbl[i].w1);
      end

      // back-to-back with a 2-clk gap, second transfer cut after 4 bits of data byte 2
      b0 = wcnt0;
      xfer(8'h00, 24'h000020, 1, 32'h7700_0000, 1'b0, 1'b0, 2);
      spi_csn = 1'b0;
      repeat (4) @(negedge clk);
      send_byte(8'h00, 8, 24'h0, 1'b0);
      send_byte(8'h00, 8, 24'h0, 1'b0);
      send_byte(8'h00, 8, 24'h0, 1'b0);
      send_byte(8'h30, 8, 24'h0, 1'b0);
      send_byte(8'h5C, 8, 24'h000030, 1'b1);
      send_byte(8'hF0, 4, 24'h0, 1'b0);
      repeat (4) @(negedge clk);
      spi_csn = 1'b1;
      repeat (10) @(negedge clk);
      chk("b2b_partial_writes", wcnt0 - b0, 2);
      chk("partial_loading", 32'(ld0), 32'd0);
      chk("hold_addr_b", 32'(a0), 32'h30);
      chk("hold_din_b", 32'(d0), 32'h5C);
      b0 = wcnt0;
      xfer(8'h00, 24'h000040, 1, 32'h3C00_0000, 1'b1, 1'b1, 8);
      chk("after_partial_writes", wcnt0 - b0, 1);

      // address incomplete: no write
      b0 = wcnt0;
      spi_csn = 1'b0;
      repeat (4) @(negedge clk);
      send_byte(8'h00, 8, 24'h0, 1'b0);
      send_byte(8'h00, 8, 24'h0, 1'b0);
      send_byte(8'h01, 8, 24'h0, 1'b0);
      repeat (4) @(negedge clk);
      spi_csn = 1'b1;
      repeat (10) @(negedge clk);
      chk("addr_incomplete_writes", wcnt0 - b0, 0);

      // reset mid-transfer, then a transfer without a command byte
      spi_csn = 1'b0;
      repeat (4) @(negedge clk);
      send_byte(8'h00, 8, 24'h0, 1'b0);
      send_byte(8'h00, 8, 24'h0, 1'b0);
      send_byte(8'h00, 8, 24'h0, 1'b0);
      send_byte(8'h50, 8, 24'h0, 1'b0);
      send_byte(8'h11, 8, 24'h000050, 1'b1);
      send_byte(8'h22, 4, 24'h0, 1'b0);
      chk("pre_abort_loading", 32'(ld0), 32'd1);
      resetn = 1'b0;
      spi_csn = 1'b1;
      spi_sclk = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_loading", 32'(ld0), 32'd0);
      chk("abort_addr_b", 32'(a0), 32'd0);
      chk("abort_din_b", 32'(d0), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (4) @(negedge clk);
      b0 = wcnt0;
      xfer(8'hF5, 24'h000060, 1, 32'h3300_0000, 1'b1, 1'b0, 8);
      chk("no_cmd_after_reset_writes", wcnt0 - b0, 0);

`ifdef SPI_ROM_LOADER_CHECKSUM_EN
      xfer(8'h00, 24'h000000, 3, 32'h0102_FF00, 1'b0, 1'b0, 8);
      chk("checksum_sum_dut0", 32'(cs0), 32'h02);
      chk("checksum_nowrite_dut1", 32'(cs1), 32'h00);
      xfer(8'h00, 24'h000100, 0, 32'h0, 1'b0, 1'b0, 8);
      chk("checksum_cleared", 32'(cs0), 32'h00);
`endif

      repeat (10) @(negedge clk);
      chk("queue0_drained", q0.size(), 0);
      chk("queue1_drained", q1.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
